alu_res_station: RTL

//  Reservation station in front of the integer ALU. Holds dispatched ALU-class

---
 rtl/alu_res_station.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_res_station.sv
// ALU reservation station: holds dispatched ALU ops, wakes sources from the CDB
// and issues the oldest ready entry to the ALU. Ports: dispatch, CDB, issue, occupancy.
package alu_rs_pkg;

  typedef enum logic [1:0] {
    OP_B_REG,
    OP_B_IMM,
    OP_B_LUI,
    OP_B_AUIPC
  } op_b_e;

  typedef struct packed {
    logic [31:0] i_pc;
    logic [31:0] imm_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [3:0]  alu_op;
    logic [2:0]  cmp_op;
    op_b_e       op_b_sel;
    logic        i_uses_rs1;
    logic        i_uses_rs2;
    logic [4:0]  rd;
  } instr_pkt;

endpackage

module alu_res_station
  import alu_rs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTAG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  instr_pkt                   disp_pkt,
  input  logic [PTAG_W-1:0]          disp_rs1_ptag,
  input  logic                       disp_rs1_rdy,
  input  logic [PTAG_W-1:0]          disp_rs2_ptag,
  input  logic                       disp_rs2_rdy,
  input  logic                       cdb_valid,
  input  logic [PTAG_W-1:0]          cdb_ptag,
  input  logic [31:0]                cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output instr_pkt                   issue_pkt,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0]  rs2_rdy_q, rs2_rdy_d;
  logic [PTAG_W-1:0] rs1_tag_q [DEPTH];
  logic [PTAG_W-1:0] rs1_tag_d [DEPTH];
  logic [PTAG_W-1:0] rs2_tag_q [DEPTH];
  logic [PTAG_W-1:0] rs2_tag_d [DEPTH];
  instr_pkt          pkt_q [DEPTH];
  instr_pkt          pkt_d [DEPTH];
  // age_q[i][j] set: entry i is older than entry j
  logic [DEPTH-1:0]  age_q [DEPTH];
  logic [DEPTH-1:0]  age_d [DEPTH];

  logic [DEPTH-1:0]  entry_rdy;
  logic [DEPTH-1:0]  older_col;
  logic [IDX_W-1:0]  sel_idx;
  logic              any_rdy;
  logic [IDX_W-1:0]  free_idx;
  logic              disp_fire;
  logic              issue_fire;
  logic              cdb_hit;
  logic [OCC_W-1:0]  occ_cnt;

  assign entry_rdy  = valid_q & rs1_rdy_q & rs2_rdy_q;
  assign any_rdy    = |entry_rdy;
  assign disp_ready = ~&valid_q;
  assign issue_valid = any_rdy && !flush;
  assign issue_fire = issue_valid && issue_ready;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  // tag 0 is the hardwired x0 mapping and never carries a result
  assign cdb_hit    = cdb_valid && (cdb_ptag != '0) && !flush;
  assign occupancy  = occ_cnt;

  // oldest-ready select: ready entry with no ready entry older than it
  always_comb begin
    sel_idx   = '0;
    older_col = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_col[j] = age_q[j][e];
      end
      if (entry_rdy[e] && ((entry_rdy & older_col) == '0)) begin
        sel_idx = IDX_W'(e);
      end
    end
  end

  always_comb begin
    issue_pkt = '0;
    if (issue_valid) begin
      issue_pkt = pkt_q[sel_idx];
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + OCC_W'(valid_q[i]);
    end
  end

  always_comb begin
    valid_d   = valid_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
    pkt_d     = pkt_q;
    age_d     = age_q;

    for (int e = 0; e < DEPTH; e++) begin
      if (cdb_hit && valid_q[e]) begin
        if (!rs1_rdy_q[e] && (rs1_tag_q[e] == cdb_ptag)) begin
          rs1_rdy_d[e]      = 1'b1;
          pkt_d[e].rs1_data = cdb_data;
        end
        if (!rs2_rdy_q[e] && (rs2_tag_q[e] == cdb_ptag)) begin
          rs2_rdy_d[e]      = 1'b1;
          pkt_d[e].rs2_data = cdb_data;
        end
      end
    end

    if (issue_fire) begin
      valid_d[sel_idx] = 1'b0;
    end

    if (disp_fire) begin
      valid_d[free_idx]   = 1'b1;
      pkt_d[free_idx]     = disp_pkt;
      rs1_tag_d[free_idx] = disp_rs1_ptag;
      rs2_tag_d[free_idx] = disp_rs2_ptag;
      rs1_rdy_d[free_idx] = 1'b0;
      rs2_rdy_d[free_idx] = 1'b0;
      if (!disp_pkt.i_uses_rs1 || disp_rs1_rdy) begin
        rs1_rdy_d[free_idx] = 1'b1;
      end else if (cdb_hit && (disp_rs1_ptag == cdb_ptag)) begin
        rs1_rdy_d[free_idx]      = 1'b1;
        pkt_d[free_idx].rs1_data = cdb_data;
      end
      if (!disp_pkt.i_uses_rs2 || disp_rs2_rdy) begin
        rs2_rdy_d[free_idx] = 1'b1;
      end else if (cdb_hit && (disp_rs2_ptag == cdb_ptag)) begin
        rs2_rdy_d[free_idx]      = 1'b1;
        pkt_d[free_idx].rs2_data = cdb_data;
      end
      age_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (IDX_W'(j) != free_idx) begin
          age_d[j][free_idx] = valid_q[j];
        end
      end
    end

    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        pkt_q[i]     <= '0;
        age_q[i]     <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      for (int i = 0; i < DEPTH; i++) begin
        rs1_tag_q[i] <= rs1_tag_d[i];
        rs2_tag_q[i] <= rs2_tag_d[i];
        pkt_q[i]     <= pkt_d[i];
        age_q[i]     <= age_d[i];
      end
    end
  end

endmodule
